aes_inv_cipher_ctrl: RTL and testbench

AES_INV_CIPHER_CTRL -- requirements
Module: aes_inv_cipher_ctrl

---
 rtl/aes_pkg.sv | 45 ++++
 rtl/inv_mix_columns.sv | 26 ++
 rtl/inv_sub_bytes.sv | 38 +++
 rtl/aes_inv_cipher_ctrl.sv | 124 ++++++++++++
 tb/tb_aes_inv_cipher_ctrl.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared types, constants and GF(2^8) helpers for the
// AES inverse cipher datapath and its controller.
package aes_pkg;

  localparam int NR = 10;
  localparam int RW = 4;
  localparam logic [RW-1:0] LAST_RK = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } fsm_t;

  function automatic logic [7:0] xt(
    input logic [7:0] b
  );
    return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
  endfunction

  function automatic logic [7:0] gm9(
    input logic [7:0] b
  );
    return xt(xt(xt(b))) ^ b;
  endfunction

  function automatic logic [7:0] gmb(
    input logic [7:0] b
  );
    return xt(xt(xt(b))) ^ xt(b) ^ b;
  endfunction

  function automatic logic [7:0] gmd(
    input logic [7:0] b
  );
    return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
  endfunction

  function automatic logic [7:0] gme(
    input logic [7:0] b
  );
    return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
  endfunction

endpackage

// File: rtl/inv_mix_columns.sv
// InvMixColumns over a 128-bit column-major state,
// byte 0 at [127:120].
module inv_mix_columns
  import aes_pkg::*;
(
  input  logic [127:0] i_state,
  output logic [127:0] o_state
);

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] w_a0, w_a1, w_a2, w_a3;
    assign w_a0 = i_state[127-32*c -: 8];
    assign w_a1 = i_state[119-32*c -: 8];
    assign w_a2 = i_state[111-32*c -: 8];
    assign w_a3 = i_state[103-32*c -: 8];
    assign o_state[127-32*c -: 8] =
      gme(w_a0) ^ gmb(w_a1) ^ gmd(w_a2) ^ gm9(w_a3);
    assign o_state[119-32*c -: 8] =
      gm9(w_a0) ^ gme(w_a1) ^ gmb(w_a2) ^ gmd(w_a3);
    assign o_state[111-32*c -: 8] =
      gmd(w_a0) ^ gm9(w_a1) ^ gme(w_a2) ^ gmb(w_a3);
    assign o_state[103-32*c -: 8] =
      gmb(w_a0) ^ gmd(w_a1) ^ gm9(w_a2) ^ gme(w_a3);
  end

endmodule

// File: rtl/inv_sub_bytes.sv
// InvSubBytes: sixteen parallel inverse S-box lookups,
// purely combinational.
module inv_sub_bytes (
  input  logic [127:0] i_data,
  output logic [127:0] o_data
);

  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  // entry x sits at bits [2047-8x -: 8]; 2047-8x == {~x,3'b111}
  function automatic logic [7:0] lut(
    input logic [7:0] x
  );
    return INV_SBOX[{~x, 3'b111} -: 8];
  endfunction

  for (genvar i = 0; i < 16; i++) begin : g_byte
    assign o_data[127-8*i -: 8] = lut(i_data[127-8*i -: 8]);
  end

endmodule

// File: rtl/aes_inv_cipher_ctrl.sv
// Iterative AES-128 inverse cipher: one round per clock,
// round keys fetched combinationally from an external store.
module aes_inv_cipher_ctrl #(
  parameter int NR = aes_pkg::NR
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  import aes_pkg::*;

  fsm_t          r_fsm;
  fsm_t          w_fsm_nxt;
  logic [127:0]  r_state;
  logic [127:0]  w_state_nxt;
  logic [RW-1:0] r_round;
  logic [RW-1:0] w_round_nxt;

  logic [127:0]  w_isr;
  logic [127:0]  w_isb;
  logic [127:0]  w_t;
  logic [127:0]  w_imc;

  // row r rotates right by r: out[r][c] = in[r][c-r]
  for (genvar c = 0; c < 4; c++) begin : g_isr_c
    for (genvar r = 0; r < 4; r++) begin : g_isr_r
      localparam int SC = (c - r + 4) % 4;
      assign w_isr[127-8*(4*c+r) -: 8] =
        r_state[127-8*(4*SC+r) -: 8];
    end
  end

  inv_sub_bytes u_isb (
    .i_data (w_isr),
    .o_data (w_isb)
  );

  assign w_t = w_isb ^ rk;

  inv_mix_columns u_imc (
    .i_state (w_t),
    .o_state (w_imc)
  );

  // state, round counter and FSM registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm   <= S_IDLE;
      r_state <= '0;
      r_round <= '0;
    end else begin
      r_fsm   <= w_fsm_nxt;
      r_state <= w_state_nxt;
      r_round <= w_round_nxt;
    end
  end

  // next state: flush beats accept and output handshake
  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_state_nxt = r_state;
    w_round_nxt = r_round;
    if (flush) begin
      w_fsm_nxt = S_IDLE;
    end else begin
      unique case (r_fsm)
        S_IDLE: begin
          if (in_valid) begin
            w_state_nxt = in_data ^ rk;
            w_round_nxt = RW'(NR - 1);
            w_fsm_nxt   = S_RUN;
          end
        end
        S_RUN: begin
          if (r_round != '0) begin
            w_state_nxt = w_imc;
            w_round_nxt = r_round - 1'b1;
          end else begin
            w_state_nxt = w_t;
            w_fsm_nxt   = S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) w_fsm_nxt = S_IDLE;
        end
        default: w_fsm_nxt = S_IDLE;
      endcase
    end
  end

  // handshake flags and key index from FSM state
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    rk_idx    = LAST_RK;
    unique case (r_fsm)
      S_IDLE: in_ready = 1'b1;
      S_RUN: begin
        busy   = 1'b1;
        rk_idx = r_round;
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        rk_idx    = '0;
      end
      default: rk_idx = LAST_RK;
    endcase
  end

  assign out_data = r_state;

endmodule

// File: tb/tb_aes_inv_cipher_ctrl.sv
// Directed bench for aes_inv_cipher_ctrl using the
// FIPS-197 C.1 and Appendix B vectors.
module tb_aes_inv_cipher_ctrl;

  localparam logic [127:0] CT0 =
    128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT0 =
    128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT1 =
    128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT1 =
    128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] INIT0 =
    128'h7ad5fda789ef4e272bca100b3d9ff59f;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [3:0]   rk_idx;
  logic [127:0] rk;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;
  logic         key_sel;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  function automatic logic [127:0] rk_of(
    input logic       ks,
    input logic [3:0] i
  );
    case ({ks, i})
      5'h00: return 128'h000102030405060708090a0b0c0d0e0f;
      5'h01: return 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
      5'h02: return 128'hb692cf0b643dbdf1be9bc5006830b3fe;
      5'h03: return 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
      5'h04: return 128'h47f7f7bc95353e03f96c32bcfd058dfd;
      5'h05: return 128'h3caaa3e8a99f9deb50f3af57adf622aa;
      5'h06: return 128'h5e390f7df7a69296a7553dc10aa31f6b;
      5'h07: return 128'h14f9701ae35fe28c440adf4d4ea9c026;
      5'h08: return 128'h47438735a41c65b9e016baf4aebf7ad2;
      5'h09: return 128'h549932d1f08557681093ed9cbe2c974e;
      5'h0a: return 128'h13111d7fe3944a17f307a78b4d2b30c5;
      5'h10: return 128'h2b7e151628aed2a6abf7158809cf4f3c;
      5'h11: return 128'ha0fafe1788542cb123a339392a6c7605;
      5'h12: return 128'hf2c295f27a96b9435935807a7359f67f;
      5'h13: return 128'h3d80477d4716fe3e1e237e446d7a883b;
      5'h14: return 128'hef44a541a8525b7fb671253bdb0bad00;
      5'h15: return 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
      5'h16: return 128'h6d88a37a110b3efddbf98641ca0093fd;
      5'h17: return 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
      5'h18: return 128'head27321b58dbad2312bf5607f8d292f;
      5'h19: return 128'hac7766f319fadc2128d12941575c006e;
      5'h1a: return 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
      default: return '0;
    endcase
  endfunction

  assign rk = rk_of(key_sel, rk_idx);

  aes_inv_cipher_ctrl #(.NR(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .rk_idx    (rk_idx),
    .rk        (rk),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  task automatic chk(
    input string        tag,
    input logic [127:0] got,
    input logic [127:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_blk(
    input logic         ks,
    input logic [127:0] ct,
    input logic [127:0] pt,
    input int           hold
  );
    logic [127:0] exp_init;
    exp_init  = ct ^ rk_of(ks, 4'd10);
    key_sel   = ks;
    in_data   = ct;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    chk("acc_ready", in_ready, 1);
    chk("acc_rkidx", rk_idx, 10);
    step();
    in_valid = 1'b0;
    in_data  = ~ct;
    chk("init_state", out_data, exp_init);
    for (int k = 1; k <= 10; k++) begin
      chk("run_flags", {out_valid, busy, in_ready, rk_idx},
          {3'b010, 4'(10 - k)});
      step();
    end
    chk("lat_valid", out_valid, 1);
    chk("plaintext", out_data, pt);
    chk("done_rkidx", rk_idx, 0);
    for (int h = 0; h < hold; h++) begin
      in_valid = h[0];
      in_data  = {4{h}};
      step();
      chk("hold_data", out_data, pt);
      chk("hold_flags", {in_ready, busy, out_valid}, 3'b011);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("ret_idle", {in_ready, out_valid, busy}, 3'b100);
  endtask

  initial begin
    logic [127:0] cts [2];
    logic [127:0] pts [2];
    logic         kss [2];
    logic         seen;
    logic         prev_hs;
    int           nacc;
    int           nout;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    key_sel   = 1'b0;
    repeat (3) step();
    chk("rst_flags", {in_ready, out_valid, busy}, 3'b100);
    chk("rst_rkidx", rk_idx, 10);
    chk("rst_data", out_data, 0);
    rst_n = 1'b1;

    // C.1 vector, exact latency and key index walk
    run_blk(1'b0, CT0, PT0, 0);
    chk("c1_init_const", CT0 ^ rk_of(1'b0, 4'd10), INIT0);

    // Appendix B vector with a different key
    run_blk(1'b1, CT1, PT1, 0);

    // backpressure for 20 cycles in DONE
    run_blk(1'b0, CT0, PT0, 20);

    // flush beats accept in IDLE
    in_data  = CT0;
    in_valid = 1'b1;
    flush    = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_noacc", {in_ready, busy}, 2'b10);

    // flush at round 5
    key_sel  = 1'b0;
    in_data  = CT0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (rk_idx == 4'd5 && busy) seen = 1'b1;
      else step();
    end
    chk("flush_reach5", seen, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_idle", {in_ready, out_valid, busy}, 3'b100);
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid) seen = 1'b1;
      step();
    end
    chk("flush_noval", seen, 0);
    run_blk(1'b0, CT0, PT0, 0);

    // async reset mid-RUN
    in_data  = CT0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_flags", {in_ready, out_valid, busy}, 3'b100);
    chk("arst_data", out_data, 0);
    chk("arst_rkidx", rk_idx, 10);
    step();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid) seen = 1'b1;
      step();
    end
    chk("arst_noval", seen, 0);

    // back-to-back with in_valid held high
    cts[0] = CT0; pts[0] = PT0; kss[0] = 1'b0;
    cts[1] = CT1; pts[1] = PT1; kss[1] = 1'b1;
    nacc = 0;
    nout = 0;
    prev_hs   = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int cyc = 0; cyc < 80 && nout < 2; cyc++) begin
      if (out_valid) begin
        chk("b2b_pt", out_data, pts[nout]);
        nout++;
      end
      if (in_ready && in_valid && nacc < 2) begin
        if (nacc == 1) chk("b2b_gap", prev_hs, 1);
        in_data = cts[nacc];
        key_sel = kss[nacc];
        nacc++;
      end else if (nacc == 2) begin
        in_valid = 1'b0;
      end
      prev_hs = out_valid;
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("b2b_count", nout, 2);
    chk("b2b_end", {in_ready, busy}, 2'b10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
